instr_mem_sync: RTL and testbench

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

---
 rtl/instr_mem_pkg.sv | 26 ++
 rtl/instr_mem_array.sv | 30 +++
 rtl/instr_mem_sync.sv | 77 +++++++
 tb/tb_instr_mem_sync.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory slice.
// Fault encoding doubles as the rsp_fault wire format.
package instr_mem_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Misalignment wins over range so a bad PC reports its first problem.
  function automatic fault_e addr_fault(input logic [1:0] lsb, input logic hi_nz);
    if (lsb != 2'b00) return FAULT_MISALIGN;
    if (hi_nz)        return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 storage, byte-enable write, registered read.
// Read and write share one edge, so a same-word read returns the old data.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [3:0]        wr_be,
  input  logic              rd_en,
  input  logic [IDXW-1:0]   rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Single-entry fetch port over instr_mem_array with fault reporting,
// a side load port and an accepted-fetch counter.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [1:0]    rsp_fault,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [3:0]    ld_be,
  output logic [31:0]   fetch_count
);

  localparam int IDXW = $clog2(DEPTH);

  rsp_state_e  state_q;
  fault_e      flt_q;
  logic        nop_q;
  logic [31:0] cnt_q;
  logic [31:0] rd_data;
  fault_e      req_flt, ld_flt;
  logic        accept, ld_ok;

  assign req_flt   = addr_fault(req_addr[1:0], |req_addr[AW-1:IDXW+2]);
  assign ld_flt    = addr_fault(ld_addr[1:0],  |ld_addr[AW-1:IDXW+2]);
  assign rsp_valid = (state_q == RSP_FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready && !reset;
  assign ld_ok     = ld_en && !reset && (ld_flt == FAULT_NONE);

  instr_mem_array #(.DEPTH(DEPTH), .IDXW(IDXW)) u_array (
    .clk     (clk),
    .wr_en   (ld_ok),
    .wr_idx  (ld_addr[IDXW+1:2]),
    .wr_data (ld_data),
    .wr_be   (ld_be),
    .rd_en   (accept),
    .rd_idx  (req_addr[IDXW+1:2]),
    .rd_data (rd_data)
  );

  // The array read register only moves on accept, so a stalled response
  // stays stable; nop_q masks it after reset and for faulting fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RSP_EMPTY;
      flt_q   <= FAULT_NONE;
      nop_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 32'(accept);
      if (accept) begin
        state_q <= RSP_FULL;
        flt_q   <= req_flt;
        nop_q   <= (req_flt != FAULT_NONE);
      end else if (rsp_ready) begin
        state_q <= RSP_EMPTY;
      end
    end
  end

  assign rsp_instr   = nop_q ? NOP_INSTR : rd_data;
  assign rsp_fault   = flt_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed and random checks of instr_mem_sync against a word-array model.
module tb_instr_mem_sync;
  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int IDXW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_ready, rsp_valid, rsp_ready, ld_en;
  logic [AW-1:0] req_addr, ld_addr;
  logic [31:0]   rsp_instr, ld_data, fetch_count;
  logic [1:0]    rsp_fault;
  logic [3:0]    ld_be;

  int errors = 0;
  int checks = 0;

  // reference model: plain word array plus the pending response
  logic [31:0] m_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;
  logic [31:0] m_cnt;

  instr_mem_sync #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a negedge, update the model with the rules, end on the next negedge.
  task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                      input logic le, input logic [AW-1:0] la, input logic [31:0] ldd,
                      input logic [3:0] lb, input logic rst, output logic rdy);
    logic acc;
    logic [31:0] w;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    ld_en = le; ld_addr = la; ld_data = ldd; ld_be = lb; reset = rst;
    #1 rdy = req_ready;
    @(posedge clk);
    acc = rv && (!m_valid || rr) && !rst;
    if (rst) begin
      m_valid = 1'b0; m_instr = NOP; m_fault = 2'b00; m_cnt = 32'd0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        if (ra % 4 != 0)           begin m_fault = 2'b01; m_instr = NOP; end
        else if (ra >= DEPTH * 4)  begin m_fault = 2'b10; m_instr = NOP; end
        else                       begin m_fault = 2'b00; m_instr = m_mem[ra / 4]; end
      end else if (rr) begin
        m_valid = 1'b0;
      end
      if (le && la % 4 == 0 && la < DEPTH * 4) begin
        w = m_mem[la / 4];
        for (int b = 0; b < 4; b++) if (lb[b]) w[8*b +: 8] = ldd[8*b +: 8];
        m_mem[la / 4] = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic rr, output logic rdy);
    step(1'b1, a, rr, 1'b0, '0, '0, 4'h0, 1'b0, rdy);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    logic rdy;
    step(1'b0, '0, 1'b1, 1'b1, a, d, be, 1'b0, rdy);
  endtask

  task automatic test_reset();
    logic rdy;
    m_valid = 1'b0; m_instr = NOP; m_fault = 2'b00; m_cnt = 32'd0;
    step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b1, rdy);
    step(1'b0, 32'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b1, rdy);
    checks++;
    if ({rsp_valid, rsp_fault, rsp_instr, fetch_count} !== {1'b0, 2'b00, NOP, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got v=%0b f=%0h i=%h c=%0d want v=0 f=0 i=%h c=0",
               rsp_valid, rsp_fault, rsp_instr, fetch_count, NOP);
    end
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom, 4'hF);
  endtask

  task automatic test_basic();
    logic rdy;
    load(32'h0, 32'h0050_0093, 4'hF);
    fetch(32'h0, 1'b1, rdy);
    checks++;
    if ({rsp_valid, rsp_fault, rsp_instr, fetch_count} !== {1'b1, 2'b00, 32'h0050_0093, 32'd1}) begin
      errors++;
      $display("FAIL basic_fetch got v=%0b f=%0h i=%h c=%0d want v=1 f=0 i=00500093 c=1",
               rsp_valid, rsp_fault, rsp_instr, fetch_count);
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    logic [31:0] held;
    fetch(32'h4, 1'b1, rdy);
    held = m_mem[1];
    for (int c = 0; c < 3; c++) begin
      fetch(32'h8, 1'b0, rdy);
      checks++;
      if (rdy !== 1'b0 || rsp_valid !== 1'b1 || rsp_instr !== held || fetch_count !== 32'd2) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got rdy=%0b v=%0b i=%h c=%0d want rdy=0 v=1 i=%h c=2",
                 c, rdy, rsp_valid, rsp_instr, fetch_count, held);
      end
    end
    fetch(32'h8, 1'b1, rdy);
    checks++;
    if (rdy !== 1'b1 || rsp_valid !== 1'b1 || rsp_instr !== m_mem[2] || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_release got rdy=%0b v=%0b i=%h c=%0d want rdy=1 v=1 i=%h c=3",
               rdy, rsp_valid, rsp_instr, fetch_count, m_mem[2]);
    end
  endtask

  task automatic test_faults();
    logic rdy;
    logic [31:0] addrs [3] = '{32'h6, 32'h400, 32'h402};
    logic [1:0]  want  [3] = '{2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 3; k++) begin
      fetch(addrs[k], 1'b1, rdy);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_fault !== want[k] || rsp_instr !== NOP) begin
        errors++;
        $display("FAIL fault_%h got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                 addrs[k], rsp_valid, rsp_fault, rsp_instr, want[k], NOP);
      end
    end
  endtask

  task automatic test_rbw();
    logic rdy;
    load(32'h10, 32'hAAAA_AAAA, 4'hF);
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h5555_5555, 4'b0011, 1'b0, rdy);
    checks++;
    if (rsp_instr !== 32'hAAAA_AAAA || rsp_fault !== 2'b00) begin
      errors++;
      $display("FAIL rbw_old got i=%h f=%0h want i=aaaaaaaa f=0", rsp_instr, rsp_fault);
    end
    fetch(32'h10, 1'b1, rdy);
    checks++;
    if (rsp_instr !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL rbw_new got i=%h want i=aaaa5555", rsp_instr);
    end
    // misaligned and out-of-range loads must leave memory alone
    load(32'h12, 32'h1234_5678, 4'hF);
    load(32'h400, 32'h1234_5678, 4'hF);
    fetch(32'h10, 1'b1, rdy);
    checks++;
    if (rsp_instr !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL bad_load_ignored got i=%h want i=aaaa5555", rsp_instr);
    end
    fetch(32'h0, 1'b1, rdy);
    checks++;
    if (rsp_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL range_load_ignored got i=%h want i=00500093", rsp_instr);
    end
  endtask

  task automatic test_reset_full();
    logic rdy;
    fetch(32'h10, 1'b0, rdy);
    step(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, rdy);
    checks++;
    if ({rsp_valid, rsp_fault, rsp_instr, fetch_count} !== {1'b0, 2'b00, NOP, 32'd0}) begin
      errors++;
      $display("FAIL reset_full got v=%0b f=%0h i=%h c=%0d want v=0 f=0 i=%h c=0",
               rsp_valid, rsp_fault, rsp_instr, fetch_count, NOP);
    end
    fetch(32'h10, 1'b1, rdy);
    checks++;
    if (rsp_instr !== 32'hAAAA_5555 || fetch_count !== 32'd1) begin
      errors++;
      $display("FAIL reset_mem_kept got i=%h c=%0d want i=aaaa5555 c=1", rsp_instr, fetch_count);
    end
  endtask

  task automatic test_wrap();
    logic rdy;
    req_valid = 1'b0; ld_en = 1'b0; reset = 1'b0; rsp_ready = 1'b1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cnt_q;
    #1;
    m_valid = 1'b0;
    m_cnt   = 32'hFFFF_FFFF;
    checks++;
    if (fetch_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preset got c=%h want c=ffffffff", fetch_count);
    end
    @(negedge clk);
    fetch(32'h0, 1'b1, rdy);
    checks++;
    if (fetch_count !== 32'd0 || rsp_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL wrap got c=%h i=%h want c=0 i=00500093", fetch_count, rsp_instr);
    end
  endtask

  task automatic test_random();
    logic rdy, rv, rr, le, rst;
    logic [AW-1:0] ra, la;
    int sel;
    for (int n = 0; n < 600; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 2) != 0);
      le  = ($urandom_range(0, 1) != 0);
      rst = ($urandom_range(0, 59) == 0);
      sel = $urandom_range(0, 9);
      ra  = (sel < 7) ? 32'($urandom_range(0, DEPTH - 1) * 4)
          : (sel < 9) ? 32'($urandom_range(0, DEPTH * 4 - 1))
          : 32'($urandom_range(DEPTH * 4, DEPTH * 8));
      la  = (sel > 1) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
      step(rv, ra, rr, le, la, $urandom, 4'($urandom), rst, rdy);
      checks++;
      if (rdy !== (rst ? rdy : rdy) || {rsp_valid, rsp_fault, rsp_instr, fetch_count}
          !== {m_valid, m_fault, m_instr, m_cnt}) begin
        errors++;
        $display("FAIL random n=%0d got v=%0b f=%0h i=%h c=%0d want v=%0b f=%0h i=%h c=%0d",
                 n, rsp_valid, rsp_fault, rsp_instr, fetch_count,
                 m_valid, m_fault, m_instr, m_cnt);
      end
      req_valid = 1'b0; rsp_ready = $urandom_range(0, 1) != 0;
      #1;
      checks++;
      if (req_ready !== (!m_valid || rsp_ready)) begin
        errors++;
        $display("FAIL random_ready n=%0d got %0b want %0b", n, req_ready, !m_valid || rsp_ready);
      end
      @(negedge clk);
      if (!m_valid || rsp_ready) m_valid = m_valid && !rsp_ready;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = 4'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_faults();
    test_rbw();
    test_reset_full();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
